// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access unit.
// Accepts one load/store, runs a req/ack handshake with data memory, aligns and
// extends load data, and pulses the register-file write port on completion.
// Requests rejected for misalignment or an illegal funct3 take the same two-cycle
// accept-to-done path as the fastest memory access, passing through WAIT with
// mem_req held low.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        done,
  output logic [1:0]  err
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_MISALGN = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // State and latched request fields
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_store;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [4:0]       r_rd;
  logic [1:0]       r_err_pend;

  // Registered outputs
  logic             r_req_ready;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [3:0]       r_mem_wstrb;
  logic [31:0]      r_mem_wdata;
  logic             r_rf_we;
  logic [4:0]       r_rf_rd;
  logic [31:0]      r_rf_wd;
  logic             r_done;
  logic [1:0]       r_err;

  // Next-state values
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_store_nxt;
  logic [2:0]       w_funct3_nxt;
  logic [1:0]       w_addr_lo_nxt;
  logic [4:0]       w_rd_nxt;
  logic [1:0]       w_err_pend_nxt;
  logic             w_req_ready_nxt;
  logic             w_mem_req_nxt;
  logic             w_mem_we_nxt;
  logic [31:0]      w_mem_addr_nxt;
  logic [3:0]       w_mem_wstrb_nxt;
  logic [31:0]      w_mem_wdata_nxt;
  logic             w_rf_we_nxt;
  logic [4:0]       w_rf_rd_nxt;
  logic [31:0]      w_rf_wd_nxt;
  logic             w_done_nxt;
  logic [1:0]       w_err_nxt;

  // Request decode helpers
  logic             w_illegal;
  logic             w_misaligned;
  logic [3:0]       w_st_wstrb;
  logic [31:0]      w_st_wdata;
  logic [7:0]       w_ld_byte;
  logic [15:0]      w_ld_half;
  logic [31:0]      w_ld_data;

  assign req_ready = r_req_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;
  assign rf_we     = r_rf_we;
  assign rf_rd     = r_rf_rd;
  assign rf_wd     = r_rf_wd;
  assign done      = r_done;
  assign err       = r_err;

  // Classify the incoming request and build store byte lanes
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    w_st_wstrb   = 4'b0000;
    w_st_wdata   = req_wdata;
    if (req_store) begin
      w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    end else begin
      w_illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) |
                  (req_funct3 == 3'b111);
    end
    w_misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                   ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    case (req_funct3[1:0])
      2'b00: begin
        w_st_wstrb = 4'b0001 << req_addr[1:0];
        w_st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_st_wstrb = 4'b1111;
        w_st_wdata = req_wdata;
      end
    endcase
  end

  // Align and extend the returned read word for the latched load type
  always_comb begin
    w_ld_byte = 8'(mem_rdata >> {r_addr_lo, 3'b000});
    w_ld_half = 16'(mem_rdata >> {r_addr_lo[1], 4'b0000});
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'h000000, w_ld_byte};
      3'b101:  w_ld_data = {16'h0000, w_ld_half};
      default: w_ld_data = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_store_nxt     = r_store;
    w_funct3_nxt    = r_funct3;
    w_addr_lo_nxt   = r_addr_lo;
    w_rd_nxt        = r_rd;
    w_err_pend_nxt  = r_err_pend;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wstrb_nxt = r_mem_wstrb;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rf_we_nxt     = 1'b0;
    w_rf_rd_nxt     = r_rf_rd;
    w_rf_wd_nxt     = r_rf_wd;
    w_done_nxt      = 1'b0;
    w_err_nxt       = ERR_OK;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_store_nxt   = req_store;
          w_funct3_nxt  = req_funct3;
          w_addr_lo_nxt = req_addr[1:0];
          w_rd_nxt      = req_rd;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_WAIT;
          if (w_illegal) begin
            w_err_pend_nxt = ERR_ILLEGAL;
          end else if (w_misaligned) begin
            w_err_pend_nxt = ERR_MISALGN;
          end else begin
            w_err_pend_nxt  = ERR_OK;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = req_store;
            w_mem_addr_nxt  = {req_addr[31:2], 2'b00};
            w_mem_wstrb_nxt = req_store ? w_st_wstrb : 4'b0000;
            w_mem_wdata_nxt = w_st_wdata;
          end
        end
      end

      S_WAIT: begin
        w_rf_rd_nxt = r_rd;
        if (r_err_pend != ERR_OK) begin
          w_state_nxt = S_FINISH;
          w_done_nxt  = 1'b1;
          w_err_nxt   = r_err_pend;
          w_rf_wd_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (mem_ack || (r_cnt == CNT_LAST)) begin
            w_state_nxt     = S_FINISH;
            w_done_nxt      = 1'b1;
            w_mem_req_nxt   = 1'b0;
            w_mem_we_nxt    = 1'b0;
            w_mem_wstrb_nxt = 4'b0000;
            if (mem_ack) begin
              w_err_nxt   = ERR_OK;
              w_rf_we_nxt = ~r_store & (r_rd != 5'd0);
              w_rf_wd_nxt = r_store ? 32'h0 : w_ld_data;
            end else begin
              w_err_nxt   = ERR_TIMEOUT;
              w_rf_wd_nxt = '0;
            end
          end
        end
      end

      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_store     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_rd        <= 5'd0;
      r_err_pend  <= ERR_OK;
      r_req_ready <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= 4'b0000;
      r_mem_wdata <= '0;
      r_rf_we     <= 1'b0;
      r_rf_rd     <= 5'd0;
      r_rf_wd     <= '0;
      r_done      <= 1'b0;
      r_err       <= ERR_OK;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_store     <= w_store_nxt;
      r_funct3    <= w_funct3_nxt;
      r_addr_lo   <= w_addr_lo_nxt;
      r_rd        <= w_rd_nxt;
      r_err_pend  <= w_err_pend_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wstrb <= w_mem_wstrb_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rf_we     <= w_rf_we_nxt;
      r_rf_rd     <= w_rf_rd_nxt;
      r_rf_wd     <= w_rf_wd_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit.
module tb_load_store_unit;

  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        done;
  logic [1:0]  err;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  err;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
  } rf_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        chk_wdata;
  } mem_exp_t;

  rf_exp_t  sb_q[$];
  mem_exp_t mem_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cyc = 0;

  logic        prev_mem_req = 1'b0;
  logic [31:0] h_addr;
  logic [3:0]  h_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: pops the expected register-file response on every done
  always @(negedge clk) begin
    rf_exp_t e;
    if (!rst) begin
      if (rf_we) chk("rf_we_only_with_done", 32'(done), 32'd1);
      if (done) begin
        done_cyc = cyc;
        chk("done_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("err", 32'(err), 32'(e.err));
          chk("rf_we", 32'(rf_we), 32'(e.we));
          if (e.we) begin
            chk("rf_rd", 32'(rf_rd), 32'(e.rd));
            chk("rf_wd", rf_wd, e.wd);
          end
        end
      end
    end
  end

  // Memory-side monitor: checks the transaction when mem_req rises and holds it stable
  always @(negedge clk) begin
    mem_exp_t m;
    if (rst) begin
      prev_mem_req = 1'b0;
    end else begin
      if (mem_req && !prev_mem_req) begin
        chk("mem_req_expected", 32'(mem_q.size() != 0), 32'd1);
        if (mem_q.size() != 0) begin
          m = mem_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(m.we));
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(m.wstrb));
          if (m.chk_wdata) chk("mem_wdata", mem_wdata, m.wdata);
        end
        h_addr  = mem_addr;
        h_wstrb = mem_wstrb;
      end else if (mem_req) begin
        chk("mem_addr_stable", mem_addr, h_addr);
        chk("mem_wstrb_stable", 32'(mem_wstrb), 32'(h_wstrb));
      end
      prev_mem_req = mem_req;
    end
  end

  // Issue one request, act as memory, and wait for the scoreboard to drain.
  // ack_dly < 0 means memory never acknowledges; e_lat > 0 checks accept-to-done.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input int ack_dly,
                       input logic [31:0] rdata, input logic [1:0] e_err, input logic e_we,
                       input logic [31:0] e_wd, input logic [3:0] e_wstrb,
                       input logic [31:0] e_mwdata, input int e_lat);
    rf_exp_t  r;
    mem_exp_t m;
    int       start;
    int       n;
    bit       ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("req_ready_wait", 32'(ok), 32'd1);
    r.err = e_err; r.we = e_we; r.rd = rd; r.wd = e_wd;
    sb_q.push_back(r);
    if (e_err == 2'd0 || e_err == 2'd3) begin
      m.we = st; m.addr = {addr[31:2], 2'b00}; m.wstrb = e_wstrb;
      m.wdata = e_mwdata; m.chk_wdata = st;
      mem_q.push_back(m);
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    start = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    if (e_err == 2'd0 || e_err == 2'd3) begin
      if (ack_dly >= 0) begin
        repeat (ack_dly) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
      end else begin
        n = 0;
        while (mem_req && n < 400) begin
          n++;
          @(negedge clk);
        end
        chk("timeout_req_cycles", 32'(n), 32'(TIMEOUT));
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(ok), 32'd1);
    if (e_lat > 0 && ok) chk("latency", 32'(done_cyc - start), 32'(e_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; req_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    //     st    f3      addr          wdata         rd  ack  rdata         err we wd            wstrb    mwdata        lat
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0,        5,  3,   32'hDEADBEEF, 0,  1, 32'hDEADBEEF, 4'b0000, 32'h0,        5);
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0,        6,  0,   32'h80FF0000, 0,  1, 32'hFFFFFF80, 4'b0000, 32'h0,        2);
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0,        7,  0,   32'h80FF0000, 0,  1, 32'h00000080, 4'b0000, 32'h0,        2);
    issue(1'b1, 3'b001, 32'h0000_0102, 32'h1234ABCD, 9,  1,   32'h0,        0,  0, 32'h0,        4'b1100, 32'hABCDABCD, 3);
    issue(1'b0, 3'b001, 32'h0000_0101, 32'h0,        4,  0,   32'h0,        1,  0, 32'h0,        4'b0000, 32'h0,        2);
    issue(1'b0, 3'b010, 32'h0000_0102, 32'h0,        4,  0,   32'h0,        1,  0, 32'h0,        4'b0000, 32'h0,        2);
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0,        4,  0,   32'h0,        2,  0, 32'h0,        4'b0000, 32'h0,        2);
    issue(1'b1, 3'b100, 32'h0000_0100, 32'h0,        4,  0,   32'h0,        2,  0, 32'h0,        4'b0000, 32'h0,        2);
    issue(1'b1, 3'b000, 32'h0000_0101, 32'h000000A5, 1,  0,   32'h0,        0,  0, 32'h0,        4'b0010, 32'hA5A5A5A5, 2);
    issue(1'b1, 3'b010, 32'h0000_0200, 32'h11223344, 1,  2,   32'h0,        0,  0, 32'h0,        4'b1111, 32'h11223344, 4);
    issue(1'b0, 3'b001, 32'h0000_0102, 32'h0,        10, 0,   32'h80017FFF, 0,  1, 32'hFFFF8001, 4'b0000, 32'h0,        2);
    issue(1'b0, 3'b101, 32'h0000_0100, 32'h0,        11, 1,   32'h12348765, 0,  1, 32'h00008765, 4'b0000, 32'h0,        3);
    issue(1'b0, 3'b010, 32'h0000_0104, 32'h0,        0,  0,   32'h55555555, 0,  0, 32'h0,        4'b0000, 32'h0,        2);
    issue(1'b0, 3'b010, 32'h0000_0400, 32'h0,        3,  -1,  32'h0,        3,  0, 32'h0,        4'b0000, 32'h0,        0);

    // Reset in the middle of a WAIT: transaction aborts with no completion
    @(negedge clk);
    chk("ready_before_abort", 32'(req_ready), 32'd1);
    mem_q.push_back('{we: 1'b0, addr: 32'h0000_0300, wstrb: 4'b0000, wdata: 32'h0, chk_wdata: 1'b0});
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_0300; req_rd = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mem_req_before_rst", 32'(mem_req), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mem_req_after_rst", 32'(mem_req), 32'd0);
    chk("done_after_rst", 32'(done), 32'd0);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_done_post_abort", 32'(done), 32'd0);
      chk("no_rf_we_post_abort", 32'(rf_we), 32'd0);
    end

    // Normal operation resumes after the abort
    issue(1'b0, 3'b010, 32'h0000_010C, 32'h0,        31, 0,   32'hCAFEF00D, 0,  1, 32'hCAFEF00D, 4'b0000, 32'h0,        2);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
